// File: rtl/handshake_arbiter_if.sv
// handshake_arbiter_if: two requester send/ack channels plus the shared
// peripheral channel and the owner indication.
interface handshake_arbiter_if #(
   parameter int DATA_W = 16
);
   logic              inSend1;
   logic [DATA_W-1:0] inData1;
   logic              outAck1;
   logic              inSend2;
   logic [DATA_W-1:0] inData2;
   logic              outAck2;
   logic              outSend;
   logic [DATA_W-1:0] outData;
   logic              inAck;
   logic [1:0]        outGrant;

   modport master (
      input  inSend1, inData1, inSend2, inData2, inAck,
      output outAck1, outAck2, outSend, outData, outGrant
   );

   modport slave (
      output inSend1, inData1, inSend2, inData2, inAck,
      input  outAck1, outAck2, outSend, outData, outGrant
   );
endinterface

// File: rtl/handshake_arbiter.sv
// handshake_arbiter: round-robin 2:1 arbiter for 4-phase send/ack channels.
// Define ARB_STATS_EN to add per-requester completed-transfer counters.
module handshake_arbiter #(
   parameter int DATA_W = 16
`ifdef ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic clkARB,
   input  logic rstARB,
`ifdef ARB_STATS_EN
   output logic [CNT_W-1:0] outCnt1,
   output logic [CNT_W-1:0] outCnt2,
`endif
   handshake_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, ACK, REL} arbStateT;

   arbStateT          state, stateNxt;
   logic [1:0]        grantQ, grantNxt;
   logic [DATA_W-1:0] dataQ, dataNxt;
   logic              lastQ, lastNxt;
   logic              sendQ, ack1Q, ack2Q;
   logic              sendNxt, ackNxt;
   logic              pick1, pick2, ownSend;

   // lastQ=1 means requester 2 owned the previous transaction
   assign pick1   = bus.inSend1 & (~bus.inSend2 | lastQ);
   assign pick2   = bus.inSend2 & (~bus.inSend1 | ~lastQ);
   assign ownSend = grantQ[0] ? bus.inSend1 : bus.inSend2;

   always_comb begin
      stateNxt = state;
      grantNxt = grantQ;
      dataNxt  = dataQ;
      lastNxt  = lastQ;
      unique case (state)
         IDLE: begin
            unique case (1'b1)
               pick1: begin
                  grantNxt = 2'b01;
                  dataNxt  = bus.inData1;
                  stateNxt = REQ;
               end
               pick2: begin
                  grantNxt = 2'b10;
                  dataNxt  = bus.inData2;
                  stateNxt = REQ;
               end
               default: ;
            endcase
         end
         REQ: if (bus.inAck) stateNxt = ACK;
         ACK: if (!ownSend) stateNxt = REL;
         REL: begin
            if (!bus.inAck) begin
               stateNxt = IDLE;
               grantNxt = 2'b00;
               lastNxt  = grantQ[1];
            end
         end
      endcase
      sendNxt = (stateNxt == REQ) || (stateNxt == ACK);
      ackNxt  = (stateNxt == ACK) || (stateNxt == REL);
   end

   always_ff @(posedge clkARB) begin
      if (rstARB) begin
         state  <= IDLE;
         grantQ <= 2'b00;
         dataQ  <= '0;
         lastQ  <= 1'b1;
         sendQ  <= 1'b0;
         ack1Q  <= 1'b0;
         ack2Q  <= 1'b0;
      end else begin
         state  <= stateNxt;
         grantQ <= grantNxt;
         dataQ  <= dataNxt;
         lastQ  <= lastNxt;
         sendQ  <= sendNxt;
         ack1Q  <= ackNxt & grantNxt[0];
         ack2Q  <= ackNxt & grantNxt[1];
      end
   end

   assign bus.outSend  = sendQ;
   assign bus.outData  = dataQ;
   assign bus.outGrant = grantQ;
   assign bus.outAck1  = ack1Q;
   assign bus.outAck2  = ack2Q;

`ifdef ARB_STATS_EN
   logic done;

   // a transaction completes on the REL->IDLE edge
   assign done = (state == REL) && !bus.inAck;

   always_ff @(posedge clkARB) begin
      if (rstARB) begin
         outCnt1 <= '0;
         outCnt2 <= '0;
      end else if (done) begin
         if (grantQ[0]) outCnt1 <= outCnt1 + CNT_W'(1);
         if (grantQ[1]) outCnt2 <= outCnt2 + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_handshake_arbiter.sv
// tb_handshake_arbiter: random requester/peripheral agents checked every
// cycle against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_handshake_arbiter;
   localparam int DATA_W = 16;
   localparam int CYCLES = 4000;
`ifdef ARB_STATS_EN
   localparam int CNT_W = 2;
`endif

   logic clkARB = 1'b0;
   logic rstARB;

   handshake_arbiter_if #(.DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
   logic [CNT_W-1:0] outCnt1, outCnt2;
   handshake_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clkARB(clkARB), .rstARB(rstARB),
      .outCnt1(outCnt1), .outCnt2(outCnt2), .bus(bus)
   );
`else
   handshake_arbiter #(.DATA_W(DATA_W)) dut (
      .clkARB(clkARB), .rstARB(rstARB), .bus(bus)
   );
`endif

   always #5 clkARB = ~clkARB;

   int checks = 0;
   int errors = 0;

   task automatic checkEq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // bench-side drive values
   logic              send [1:2];
   logic [DATA_W-1:0] data [1:2];
   logic              ack;

   // agent state: 0 idle, 1 requesting, 2 waiting for ack release
   int rq [1:2];
   int rDelay [1:2];
   int waitCyc [1:2];
   int pDelay;

   // reference model
   int                owner, last;
   bit                ackSeen, dropSeen;
   logic [DATA_W-1:0] expWord;
   int                cnt1m, cnt2m, done1, done2, maxWait, resets;

   task automatic drive();
      bus.inSend1 = send[1];
      bus.inData1 = data[1];
      bus.inSend2 = send[2];
      bus.inData2 = data[2];
      bus.inAck   = ack;
   endtask

   function automatic int pickDelay();
      return ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 2));
   endfunction

   function automatic logic ackOf(input int n);
      return (n == 1) ? bus.outAck1 : bus.outAck2;
   endfunction

   task automatic startReq(input int n);
      send[n]    = 1'b1;
      data[n]    = DATA_W'($urandom);
      rq[n]      = 1;
      rDelay[n]  = int'($urandom_range(0, 3));
      waitCyc[n] = 0;
   endtask

   initial begin
      rstARB = 1'b1;
      for (int n = 1; n <= 2; n++) begin
         send[n] = 1'b0; data[n] = '0; rq[n] = 0;
         rDelay[n] = 0; waitCyc[n] = 0;
      end
      ack = 1'b0; pDelay = 0;
      owner = 0; last = 2; ackSeen = 0; dropSeen = 0; expWord = '0;
      cnt1m = 0; cnt2m = 0; done1 = 0; done2 = 0; maxWait = 0; resets = 0;
      drive();

      for (int c = 0; c < CYCLES; c++) begin
         @(negedge clkARB);

         // advance the model with the inputs seen at the last edge
         if (rstARB) begin
            owner = 0; last = 2; ackSeen = 0; dropSeen = 0;
            expWord = '0; cnt1m = 0; cnt2m = 0;
         end else if (owner == 0) begin
            if (send[1] && (!send[2] || last == 2)) owner = 1;
            else if (send[2]) owner = 2;
            if (owner != 0) begin
               expWord = data[owner]; ackSeen = 0; dropSeen = 0;
            end
         end else if (!ackSeen) begin
            ackSeen = ack;
         end else if (!dropSeen) begin
            dropSeen = !send[owner];
         end else if (!ack) begin
            if (owner == 1) begin
               cnt1m = (cnt1m + 1) % (1 << `ifdef ARB_STATS_EN CNT_W `else 16 `endif);
               done1++;
            end else begin
               cnt2m = (cnt2m + 1) % (1 << `ifdef ARB_STATS_EN CNT_W `else 16 `endif);
               done2++;
            end
            last = owner; owner = 0;
         end

         checkEq("outSend", 32'(bus.outSend), 32'(owner != 0 && !dropSeen));
         checkEq("outAck1", 32'(bus.outAck1), 32'(owner == 1 && ackSeen));
         checkEq("outAck2", 32'(bus.outAck2), 32'(owner == 2 && ackSeen));
         checkEq("outGrant", 32'(bus.outGrant),
                 (owner == 1) ? 32'd1 : (owner == 2) ? 32'd2 : 32'd0);
         checkEq("outData", 32'(bus.outData), 32'(expWord));
`ifdef ARB_STATS_EN
         checkEq("outCnt1", 32'(outCnt1), 32'(cnt1m));
         checkEq("outCnt2", 32'(outCnt2), 32'(cnt2m));
`endif

         if (c == 1) begin
            // release reset into a tie with fixed words
            rstARB = 1'b0;
            startReq(1); data[1] = 16'h00A5;
            startReq(2); data[2] = 16'h1234;
         end else if (c > 1) begin
            for (int n = 1; n <= 2; n++) begin
               case (rq[n])
                  0: if ($urandom_range(0, 3) == 0) startReq(n);
                  1: begin
                     if (bus.outGrant != 2'(n)) begin
                        waitCyc[n]++;
                        if (waitCyc[n] > maxWait) maxWait = waitCyc[n];
                        if ($urandom_range(0, 49) == 0) begin
                           send[n] = 1'b0; rq[n] = 0;
                        end
                     end else begin
                        waitCyc[n] = 0;
                        if ($urandom_range(0, 3) == 0) data[n] = DATA_W'($urandom);
                        if (ackOf(n)) begin
                           if (rDelay[n] == 0) begin
                              send[n] = 1'b0; rq[n] = 2;
                           end else rDelay[n]--;
                        end
                     end
                  end
                  default: if (!ackOf(n)) rq[n] = 0;
               endcase
            end

            if (bus.outSend && !ack) begin
               if (pDelay == 0) begin ack = 1'b1; pDelay = pickDelay(); end
               else pDelay--;
            end else if (!bus.outSend && ack) begin
               if (pDelay == 0) begin ack = 1'b0; pDelay = pickDelay(); end
               else pDelay--;
            end else if (!bus.outSend && !ack && bus.outGrant == 2'b00 &&
                         $urandom_range(0, 19) == 0) begin
               ack = 1'b1;
            end

            if (rstARB) begin
               rstARB = 1'b0;
            end else if (owner != 0 && ackSeen && !dropSeen &&
                         $urandom_range(0, 29) == 0) begin
               rstARB = 1'b1;
               resets++;
               for (int n = 1; n <= 2; n++)
                  if (rq[n] != 1) startReq(n);
            end
         end
         drive();
      end

      checkEq("done1", 32'(done1 > 0), 32'd1);
      checkEq("done2", 32'(done2 > 0), 32'd1);
      checkEq("maxWait", 32'(maxWait < 200), 32'd1);
      checkEq("resets", 32'(resets > 0), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/handshake_arbiter.md
Name: handshake_arbiter

Overview:
- Shares one peripheral send/ack channel between two requester channels (CPU side 1 and 2).
- All three channels use a 4-phase send/ack handshake: send up, ack up, send down, ack down.
- Sits between the CPU's two send/ack ports and a single peripheral's inSend/inData/outAck port.
- Grants the channel with round-robin fairness and forwards the latched data word for the whole transaction.

Parameters:
DATA_W, 16, width of data words on all channels
CNT_W, 16, width of per-requester transfer counters (ARB_STATS_EN only)

Ports:
clkARB  input  1  single clock; all state updates on rising edge
rstARB  input  1  synchronous, active-high reset
inSend1  input  1  requester 1 send/request level
inData1  input  DATA_W  requester 1 data; stable while inSend1=1
outAck1  output  1  ack to requester 1
inSend2  input  1  requester 2 send/request level
inData2  input  DATA_W  requester 2 data; stable while inSend2=1
outAck2  output  1  ack to requester 2
outSend  output  1  send to peripheral
outData  output  DATA_W  data to peripheral
inAck  input  1  ack from peripheral
outGrant  output  2  one-hot current owner (01=req1, 10=req2, 00=none)
outCnt1  output  CNT_W  completed transfers, requester 1 (ARB_STATS_EN only)
outCnt2  output  CNT_W  completed transfers, requester 2 (ARB_STATS_EN only)

Behaviour:
- All outputs are registered. Reset (rstARB=1 at a clock edge) sets:
  - every output to 0 and state to IDLE;
  - the data register to 0;
  - lastGrant=2, so requester 1 wins the first tie.
- Reset is synchronous and takes priority over any state, including mid-transaction. The peripheral and requesters then see send/ack drop on the next edge.
- States and transitions (each transition takes effect at the next edge):
  - IDLE: outSend=0, outAck1=outAck2=0, outGrant=00.
    - If exactly one inSendN=1, grant N.
    - If both are 1, grant the requester that is not lastGrant.
    - On grant: latch inDataN into the data register, set outGrant, go REQ.
  - REQ: outSend=1, outData=latched word.
    - If inAck=1, go ACK.
    - With no ack the arbiter waits indefinitely (no timeout).
  - ACK: outSend=1, outAckN=1 for the granted N only.
    - If the granted inSendN=0, go REL.
  - REL: outSend=0, outAckN stays 1.
    - If inAck=0, then outAckN=0, lastGrant=N, outGrant=00, and the arbiter goes IDLE.
- Latency:
  - request seen to outSend=1: 1 cycle;
  - inAck=1 to outAckN=1: 1 cycle;
  - inSendN=0 to outSend=0: 1 cycle;
  - inAck=0 to outAckN=0: 1 cycle.
- Minimum transaction: 4 cycles plus the peripheral's response delay. The earliest next grant comes 1 cycle after returning to IDLE.
- Data stability: outData holds the latched word from the REQ entry edge until the next grant. Changes on inDataN after grant are ignored.
- Non-granted requester: its inSend is held pending and its outAck stays 0. Ungranted requests are never dropped.
- Simultaneous events:
  - Both requests arriving in the same cycle resolve by round-robin.
  - A new request arriving during REL is serviced only after IDLE.
  - A requester that drops inSend before being granted is simply not granted; nothing is latched.
- Protocol violation: inAck=1 while in IDLE is ignored. outSend stays 0.
- Round-robin fairness: with both requesters asserting continuously, grants strictly alternate 1,2,1,2...

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - outCnt1 and outCnt2 exist, reset to 0.
  - outCntN increments by 1 on the REL->IDLE edge of a transaction granted to N.
  - The counters wrap modulo 2^CNT_W (all-ones + 1 = 0).
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
1. Single requester: inData1=16'h00A5, inSend1=1; peripheral acks 2 cycles after outSend. Required response:
   - outGrant=01 and outSend=1 with outData=00A5;
   - outAck1 asserts 1 cycle after inAck;
   - after the full 4-phase handshake, back in IDLE with outAck1=0.
2. Tie after reset: inSend1=inSend2=1 in the same cycle. Required response:
   - requester 1 is granted first (outData=inData1), then requester 2;
   - with both held asserted, grants continue 1,2,1,2 for 4 transactions.
3. Data change after grant: change inData2 from 16'h1234 to 16'hFFFF one cycle after requester 2 is granted. Required response: outData stays 1234 until the transaction completes.
4. Slow peripheral: inAck held 0 for 20 cycles in REQ. Required response:
   - outSend stays 1 and outAck1=outAck2=0 throughout;
   - the handshake completes normally once inAck=1.
5. Reset mid-transaction: assert rstARB while in ACK. Required response:
   - next edge: outSend=0, outAckN=0, outGrant=00;
   - the first grant after release goes to requester 1 on a tie.
6. ARB_STATS_EN with CNT_W=2: 5 transactions from requester 1 and 1 from requester 2. Required response: outCnt1 reads 1,2,3,0,1 and outCnt2=1.
